// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed hex display driver.
// Shows a DIGITS-wide hex value one digit per slot. Each slot starts with a
// short anti-ghost blank. The displayed value only changes at frame
// boundaries. Leading zeros can be suppressed, and the segment and digit
// polarities are set by parameters.
module hex_display_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 1024,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]     GUARD_C = CW'(GUARD);
  localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  cnt_wrap, frame_end;

  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;

  logic [DIGITS-1:0]     lead_blank;
  logic                  zero_run;
  logic [3:0]            nib;
  logic                  cur_dp, cur_blank, show;
  logic [DIGITS-1:0]     onehot;
  logic [6:0]            seg_hi;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     dig_en_q, dig_en_d;

  // Slot timing: prescale counter and slot index, with the frame boundary on the last count of the last slot
  always_comb begin
    cnt_wrap  = (cnt_q == CNT_MAX);
    frame_end = cnt_wrap && (idx_q == IDX_MAX);
    cnt_d     = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Shadow capture and tear-free transfer to the display register at frame boundaries
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (load) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
      // A load on the boundary bypasses the shadow, so nothing is left pending.
      if (frame_end) begin
        disp_d    = value;
        disp_dp_d = dp_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (frame_end && pending_q) begin
      disp_d    = shadow_q;
      disp_dp_d = shadow_dp_q;
      pending_d = 1'b0;
    end
  end

  // Leading-zero map: digit i>0 is blankable when it and every higher digit are zero with no decimal point
  always_comb begin
    lead_blank = '0;
    zero_run   = 1'b1;
    for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
      zero_run = zero_run && (disp_q[4*(DIGITS-1-k) +: 4] == 4'h0) && !disp_dp_q[DIGITS-1-k];
      lead_blank[DIGITS-1-k] = zero_run;
    end
  end

  // Per-slot digit select, hex decode and polarity; outputs are off during the guard and for suppressed digits
  always_comb begin
    nib       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = disp_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = lz_en && lead_blank[i];
        onehot[i] = 1'b1;
      end
    end
    unique case (nib)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      default: seg_hi = 7'h71;
    endcase
    show     = (cnt_q >= GUARD_C) && !cur_blank;
    dig_en_d = DIG_OFF;
    seg_d    = SEG_OFF;
    dp_d     = DP_OFF;
    if (show) begin
      dig_en_d = onehot ^ DIG_OFF;
      seg_d    = seg_hi ^ SEG_OFF;
      dp_d     = cur_dp ^ DP_OFF;
    end
  end

  // State and output registers; reset clears the stored values and forces the display off
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      dig_en_q    <= DIG_OFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_en_q    <= dig_en_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign pending    = pending_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_hex_display_mux.sv
// Testbench for hex_display_mux (DIGITS=4, PRESCALE=8, GUARD=2, active-low).
// A time-based reference model predicts every output on every clock.
// Table vectors, directed corner sequences and random traffic drive the DUT.
module tb_hex_display_mux;

  localparam int unsigned D = 4;
  localparam int unsigned P = 8;
  localparam int unsigned G = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_en;
  logic        pending;
  logic        frame_done;

  always #5 clk = ~clk;

  hex_display_mux #(
    .DIGITS(D), .PRESCALE(P), .GUARD(G),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .value(value), .load(load), .dp_in(dp_in),
    .lz_en(lz_en), .seg(seg), .dp(dp), .dig_en(dig_en), .pending(pending),
    .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: m_t counts clock edges since reset release.
  int unsigned m_t;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;
  logic        m_was_boundary;
  int          cap_slot;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_en;
  logic        e_pend, e_fd;

  logic [6:0]  cap_seg [4];
  logic        cap_dp  [4];
  logic [3:0]  cap_en  [4];
  int unsigned ones_seen;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dpv;
    logic            lz;
    logic [3:0][6:0] eseg;   // expected seg per digit, {d3,d2,d1,d0}
    logic [3:0]      edp;    // expected dp pin level per digit
    logic [3:0]      eon;    // 1 = digit expected to be lit
  } vec_t;
  vec_t tbl [8];

  function automatic logic [6:0] hex_hi(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_shadow = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 1'b0;
    m_was_boundary = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int unsigned c, s;
    logic bnd, blank;
    logic [3:0] n;
    c = m_t % P;
    s = (m_t / P) % D;
    bnd = (c == P - 1) && (s == D - 1);
    blank = lz_en && (s > 0) && ((m_disp >> (4 * s)) == 16'h0) && ((m_ddp >> s) == 4'h0);
    n = 4'((m_disp >> (4 * s)) & 16'hF);
    if (c >= G && !blank) begin
      e_en  = ~(4'b0001 << s);
      e_seg = ~hex_hi(n);
      e_dp  = ~m_ddp[s];
    end else begin
      e_en  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end
    cap_slot = (c == P - 1) ? int'(s) : -1;
    if (load) begin
      m_shadow = value;
      m_sdp    = dp_in;
      if (bnd) begin
        m_disp = value; m_ddp = dp_in; m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (bnd && m_pend) begin
      m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
    end
    m_was_boundary = bnd;
    m_t++;
    e_pend = m_pend;
    e_fd   = ((m_t % P) == P - 1) && (((m_t / P) % D) == D - 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("dig_en", 32'(dig_en), 32'(e_en));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("pending", 32'(pending), 32'(e_pend));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (cap_slot >= 0) begin
      cap_seg[cap_slot] = seg;
      cap_dp[cap_slot]  = dp;
      cap_en[cap_slot]  = dig_en;
    end
    if (dig_en !== 4'hF && seg === 7'h79) ones_seen++;
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_dig_en"}, 32'(dig_en), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_pending"}, 32'(pending), 32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    load   = 1'b0;
    #1;
    reset_outputs_check("rst_async");
    repeat (2) @(posedge clk);
    #1;
    reset_outputs_check("rst_hold");
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic goto_pos(input int unsigned pos);
    while ((m_t % (D * P)) != pos) step();
  endtask

  // Wait for the next frame boundary, then run one whole frame capturing each slot's last count.
  task automatic show_frame();
    int unsigned n;
    for (int i = 0; i < 4; i++) begin
      cap_seg[i] = 'x; cap_dp[i] = 1'bx; cap_en[i] = 'x;
    end
    n = 0;
    do begin step(); n++; end while (!m_was_boundary && n < 2 * D * P);
    repeat (D * P) step();
  endtask

  task automatic wait_fd(output int unsigned n);
    n = 0;
    do begin step(); n++; end while (frame_done !== 1'b1 && n < 2 * D * P);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n, pend_cycles;
    logic [3:0] een;

    tbl[0] = '{16'h1A3F, 4'h0, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}, 4'hF, 4'hF};
    tbl[1] = '{16'h0005, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF, 4'h1};
    tbl[2] = '{16'h0005, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 4'hF};
    tbl[3] = '{16'h0000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 4'h1};
    tbl[4] = '{16'h0700, 4'h2, 1'b1, {7'h7F, 7'h78, 7'h40, 7'h40}, 4'hD, 4'h7};
    tbl[5] = '{16'h0000, 4'h4, 1'b1, {7'h7F, 7'h40, 7'h40, 7'h40}, 4'hB, 4'h7};
    tbl[6] = '{16'h89BC, 4'h9, 1'b1, {7'h00, 7'h10, 7'h03, 7'h46}, 4'h6, 4'hF};
    tbl[7] = '{16'hDE42, 4'h0, 1'b0, {7'h21, 7'h06, 7'h19, 7'h24}, 4'hF, 4'hF};

    load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0; ones_seen = 0;
    resetn = 1'b1;
    model_reset();
    #1;
    apply_reset();

    // Load at counter 3 of slot 1: pending until the frame boundary, then shown next frame.
    goto_pos(P + 3);
    value = 16'h1A3F; dp_in = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    pend_cycles = 0;
    while (pending === 1'b1 && pend_cycles < 2 * D * P) begin
      pend_cycles++;
      step();
    end
    chk("pending_span", pend_cycles, (D * P - 1) - (P + 3));
    repeat (D * P) step();
    chk("f1a3f_d0_seg", 32'(cap_seg[0]), 32'h0E);
    chk("f1a3f_d3_seg", 32'(cap_seg[3]), 32'h79);

    // frame_done period
    wait_fd(n);
    chk("frame_done_seen", 32'(frame_done), 32'h1);
    wait_fd(n);
    chk("frame_period", n, D * P);

    // Table-driven display vectors
    for (int v = 0; v < 8; v++) begin
      lz_en = tbl[v].lz;
      repeat ($urandom_range(0, 40)) step();
      value = tbl[v].val; dp_in = tbl[v].dpv; load = 1'b1;
      step();
      load = 1'b0;
      show_frame();
      for (int i = 0; i < 4; i++) begin
        een = tbl[v].eon[i] ? ~(4'b0001 << i) : 4'hF;
        chk($sformatf("tbl%0d_seg%0d", v, i), 32'(cap_seg[i]), 32'(tbl[v].eseg[i]));
        chk($sformatf("tbl%0d_dp%0d", v, i), 32'(cap_dp[i]), 32'(tbl[v].edp[i]));
        chk($sformatf("tbl%0d_en%0d", v, i), 32'(cap_en[i]), 32'(een));
      end
    end

    // Two loads in one frame: the last one wins, the first never reaches the display.
    lz_en = 1'b0;
    goto_pos(2);
    ones_seen = 0;
    value = 16'h1111; dp_in = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    goto_pos(20);
    value = 16'h2222; load = 1'b1;
    step();
    load = 1'b0;
    show_frame();
    chk("no_1111_shown", ones_seen, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("last_wins_seg%0d", i), 32'(cap_seg[i]), 32'h24);

    // Load in the frame_done cycle goes straight to the display.
    wait_fd(n);
    chk("fd_before_load", 32'(frame_done), 32'h1);
    value = 16'h4C7B; dp_in = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    chk("boundary_load_pending", 32'(pending), 32'h0);
    step();
    step();
    chk("boundary_load_guard", 32'(dig_en), 32'hF);
    step();
    chk("boundary_load_en0", 32'(dig_en), 32'hE);
    chk("boundary_load_seg0", 32'(seg), 32'h03);
    chk("boundary_load_pending2", 32'(pending), 32'h0);

    // Reset in the middle of slot 2 with a value on display.
    goto_pos(2 * P + 4);
    apply_reset();
    repeat (D * P) step();
    for (int i = 0; i < 4; i++) chk($sformatf("post_rst_seg%0d", i), 32'(cap_seg[i]), 32'h40);

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      load  = ($urandom_range(0, 15) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      step();
    end
    load = 1'b0;
    repeat (D * P) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
